// File: rtl/jam_cost_server.sv
// ---------------------------------------------------------------------------
// jam_cost_server
//   Responder side of the assignment solver's cost-fetch interface. An 8x8
//   cost table is first filled from a valid/ready byte stream and then served
//   to the solver with one clock of latency. The solver's final result is
//   captured once, and done stays set until reset.
//
// Ports
//   CLK, RST          clock, asynchronous active-low reset
//   load_valid/data   table load stream, worker-major (entry (w,j) = beat w*8+j)
//   load_ready        high while the block accepts load beats
//   table_full        all 64 entries loaded, serving active
//   W, J / Cost       worker/job request, registered cost returned next cycle
//   Valid, MatchCount, MinCost   solver result strobe and payload
//   res_match, res_cost, done    captured result, sticky until reset
//   checksum          running sum of all accepted load beats
// ---------------------------------------------------------------------------
module jam_cost_server #(
    parameter int COST_W = 7,
    parameter int MIN_W  = 10,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_valid,
    input  logic [COST_W-1:0] load_data,
    output logic              load_ready,
    output logic              table_full,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [CNT_W-1:0]  MatchCount,
    input  logic [MIN_W-1:0]  MinCost,
    output logic [CNT_W-1:0]  res_match,
    output logic [MIN_W-1:0]  res_cost,
    output logic              done,
    output logic [12:0]       checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, SERVE, DONE} state_t;

    state_t              state_q;
    logic [5:0]          wr_ptr_q;
    logic [5:0]          wr_ptr_d;
    logic                load_ready_q;
    logic                table_full_q;
    logic [COST_W-1:0]   cost_q;
    logic [CNT_W-1:0]    res_match_q;
    logic [MIN_W-1:0]    res_cost_q;
    logic                done_q;
    logic [12:0]         checksum_q;
    logic                accept;

    // Table storage is deliberately not reset; a reload overwrites every entry.
    logic [COST_W-1:0]   mem [64];

    assign accept   = (state_q == LOAD) && load_valid && load_ready_q;
    assign wr_ptr_d = wr_ptr_q + 6'd1;   // wraps to 0 after beat 63

    always_ff @(posedge CLK) begin
        if (accept) mem[wr_ptr_q] <= load_data;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            load_ready_q <= 1'b0;
            table_full_q <= 1'b0;
            cost_q       <= '0;
            res_match_q  <= '0;
            res_cost_q   <= '0;
            done_q       <= 1'b0;
            checksum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q      <= LOAD;
                    load_ready_q <= 1'b1;
                end
                LOAD: begin
                    cost_q <= '0;
                    if (accept) begin
                        wr_ptr_q   <= wr_ptr_d;
                        checksum_q <= checksum_q + 13'(load_data);
                        if (wr_ptr_q == 6'd63) begin
                            state_q      <= SERVE;
                            load_ready_q <= 1'b0;
                            table_full_q <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    cost_q <= mem[{W, J}];
                    if (Valid) begin
                        res_match_q <= MatchCount;
                        res_cost_q  <= MinCost;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Result frozen; only reset leaves this state.
                    cost_q <= mem[{W, J}];
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign table_full = table_full_q;
    assign Cost       = cost_q;
    assign res_match  = res_match_q;
    assign res_cost   = res_cost_q;
    assign done       = done_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_jam_cost_server.sv
module tb_jam_cost_server;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        load_valid = 1'b0;
    logic [6:0]  load_data  = '0;
    logic        load_ready;
    logic        table_full;
    logic [2:0]  W = '0;
    logic [2:0]  J = '0;
    logic [6:0]  Cost;
    logic        Valid = 1'b0;
    logic [3:0]  MatchCount = '0;
    logic [9:0]  MinCost = '0;
    logic [3:0]  res_match;
    logic [9:0]  res_cost;
    logic        done;
    logic [12:0] checksum;

    int checks = 0;
    int errors = 0;
    int acc, rdy;

    jam_cost_server dut (
        .CLK(CLK), .RST(RST),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .table_full(table_full), .W(W), .J(J), .Cost(Cost),
        .Valid(Valid), .MatchCount(MatchCount), .MinCost(MinCost),
        .res_match(res_match), .res_cost(res_cost), .done(done), .checksum(checksum)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Streams n beats. Data is base+index unless cval is set (then v).
    // Valid is pulsed while the accept count equals valid_at.
    task automatic load(input int n, input bit toggle, input bit cval, input logic [6:0] v,
                        input int base, input int valid_at, output int nacc, output int nrdy);
        int  cyc;
        int  d;
        bit  lv, take;
        nacc = 0; nrdy = 0; cyc = 0;
        while (nacc < n && cyc < 400) begin
            lv = toggle ? (cyc % 2 == 0) : 1'b1;
            d  = base + nacc;
            load_valid = lv;
            load_data  = cval ? v : d[6:0];
            Valid      = (nacc == valid_at);
            MatchCount = 4'd9;
            MinCost    = 10'd100;
            if (load_ready) nrdy++;
            take = lv && load_ready;
            if (nacc > 0 || take) check("cost_zero_in_load", {25'd0, Cost}, 32'd0);
            tick();
            if (take) nacc++;
            cyc++;
        end
        load_valid = 1'b0;
        Valid      = 1'b0;
        if (cyc >= 400) check("load_timeout", nacc, n);
    endtask

    // Sweeps all 64 (W,J) pairs and checks both the one-cycle latency
    // (Cost unchanged before the edge) and the returned value after it.
    task automatic sweep(input bit cval, input logic [6:0] v);
        int prev;
        int exp;
        prev = 0;
        for (int i = 0; i < 64; i++) begin
            W = 3'(i >> 3);
            J = 3'(i & 7);
            exp = cval ? int'(v) : i;
            if (i > 0) check("cost_latency", {25'd0, Cost}, prev);
            tick();
            check("cost", {25'd0, Cost}, exp);
            prev = exp;
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #3;
        check("rst_load_ready", {31'd0, load_ready}, 0);
        check("rst_table_full", {31'd0, table_full}, 0);
        check("rst_cost",       {25'd0, Cost}, 0);
        check("rst_res_match",  {28'd0, res_match}, 0);
        check("rst_res_cost",   {22'd0, res_cost}, 0);
        check("rst_done",       {31'd0, done}, 0);
        check("rst_checksum",   {19'd0, checksum}, 0);
        RST = 1'b1;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        do_reset();

        // Scenario 1: full-rate load of w*8+j
        load(63, 1'b0, 1'b0, 7'd0, 0, -1, acc, rdy);
        check("s1_ready_63", rdy, 63);
        check("s1_not_full_63", {31'd0, table_full}, 0);
        check("s1_checksum_63", {19'd0, checksum}, 1953);
        load(1, 1'b0, 1'b0, 7'd0, 63, -1, acc, rdy);
        check("s1_ready_last", rdy, 1);
        check("s1_table_full", {31'd0, table_full}, 1);
        check("s1_ready_low", {31'd0, load_ready}, 0);
        check("s1_checksum", {19'd0, checksum}, 2016);

        // Scenario 3: sweep all pairs; W=7,J=7 is last and gives 63
        sweep(1'b0, 7'd0);
        check("s3_last_cost", {25'd0, Cost}, 63);

        // Scenario 4: capture, then a later Valid is ignored
        MatchCount = 4'd3; MinCost = 10'd521; Valid = 1'b1;
        W = 3'd1; J = 3'd2;
        tick();
        Valid = 1'b0;
        check("s4_res_match", {28'd0, res_match}, 3);
        check("s4_res_cost",  {22'd0, res_cost}, 521);
        check("s4_done",      {31'd0, done}, 1);
        check("s4_cost_capture_cycle", {25'd0, Cost}, 10);
        tick();
        MatchCount = 4'd5; MinCost = 10'd777; Valid = 1'b1;
        tick();
        Valid = 1'b0;
        tick();
        check("s4_hold_match", {28'd0, res_match}, 3);
        check("s4_hold_cost",  {22'd0, res_cost}, 521);
        check("s4_hold_done",  {31'd0, done}, 1);
        W = 3'd2; J = 3'd5;
        tick();
        check("s4_done_cost", {25'd0, Cost}, 21);

        // Reset from DONE clears results; scenarios 2 and 5: toggled load, Valid at beat 20
        do_reset();
        load(64, 1'b1, 1'b0, 7'd0, 0, 20, acc, rdy);
        check("s2_accepts", acc, 64);
        check("s2_table_full", {31'd0, table_full}, 1);
        check("s2_checksum", {19'd0, checksum}, 2016);
        check("s5_done", {31'd0, done}, 0);
        check("s5_res_match", {28'd0, res_match}, 0);
        check("s5_res_cost", {22'd0, res_cost}, 0);
        W = 3'd7; J = 3'd7;
        tick();
        check("s2_cost_77", {25'd0, Cost}, 63);

        // Scenario 6: reset after 30 beats, then reload all 127
        do_reset();
        load(30, 1'b0, 1'b1, 7'd5, 0, -1, acc, rdy);
        check("s6_checksum_30", {19'd0, checksum}, 150);
        do_reset();
        load(64, 1'b0, 1'b1, 7'd127, 0, -1, acc, rdy);
        check("s6_ready", rdy, 64);
        check("s6_table_full", {31'd0, table_full}, 1);
        check("s6_checksum", {19'd0, checksum}, 8128);
        sweep(1'b1, 7'd127);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Responder end of the job-assignment solver's cost-fetch interface.
- The solver drives a worker index W and a job index J; this block returns the 7-bit Cost for that worker/job pair from an internal 8x8 table.
- The table is first filled from a byte-stream load port with a valid/ready handshake.
- The block also captures the solver's final result (MatchCount, MinCost) when the solver asserts Valid, and reports completion.

Parameters:
- COST_W, 7, width of one cost entry and of load_data/Cost.
- MIN_W, 10, width of the captured MinCost result.
- CNT_W, 4, width of the captured MatchCount result.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- load_valid  input  1  load_data holds a valid table entry.
- load_data  input  COST_W  table entry, streamed in worker-major order.
- load_ready  output  1  block accepts a load beat this cycle.
- table_full  output  1  all 64 entries are loaded and the serve phase is active.
- W  input  3  worker index requested by the solver.
- J  input  3  job index requested by the solver.
- Cost  output  COST_W  registered cost of entry (W,J).
- Valid  input  1  solver result valid.
- MatchCount  input  CNT_W  solver match count.
- MinCost  input  MIN_W  solver minimum total cost.
- res_match  output  CNT_W  captured MatchCount.
- res_cost  output  MIN_W  captured MinCost.
- done  output  1  result captured; sticky until reset.
- checksum  output  13  running sum of all accepted load_data values.

Behaviour:
- Reset (RST low, asynchronous):
  - state IDLE; write pointer 0.
  - Outputs: load_ready 0, table_full 0, Cost 0, res_match 0, res_cost 0, done 0, checksum 0.
  - Table contents are not cleared.
- States: IDLE, LOAD, SERVE, DONE.
- IDLE: unconditionally goes to LOAD on the next edge; load_ready becomes 1 on entry to LOAD.
- LOAD:
  - A beat is accepted when load_valid and load_ready are both high.
  - On accept: table entry at wr_ptr takes load_data. wr_ptr[5:3] is the worker index and wr_ptr[2:0] is the job index, so entry (w,j) is beat w*8+j.
  - On accept: wr_ptr increments and checksum adds load_data (zero-extended).
  - No accept when load_valid is low; state holds.
  - Accepting beat 63 causes, on the same edge: state SERVE, load_ready 0, table_full 1. wr_ptr wraps to 0.
  - Cost is held at 0 throughout LOAD.
  - Valid is ignored in LOAD; no capture occurs.
- SERVE:
  - Every cycle, Cost takes the entry at {W,J}. Latency is exactly one clock from W/J to Cost.
  - Cost is valid for any W/J; there is no request strobe.
  - load_valid is ignored and load_ready stays 0.
  - When Valid is high: res_match takes MatchCount, res_cost takes MinCost, done becomes 1, state DONE.
  - Cost continues updating during the capture cycle.
- DONE:
  - Cost keeps serving with the same one-cycle latency.
  - done, res_match and res_cost hold.
  - Further Valid pulses are ignored.
  - The only exit is reset.
- checksum: maximum 64*127 = 8128, which fits in 13 bits with no overflow. It freezes after beat 63.
- Reset mid-LOAD:
  - wr_ptr and checksum return to 0; table_full 0.
  - After reset the full 64-beat load is repeated; stale entries are overwritten.
- Reset in SERVE/DONE:
  - Clears done and res_*.
  - The table is retained but not served until reloaded.
- Back-to-back beats: one accept per cycle at full rate. load_ready is never deasserted mid-load except by reset.

Test Plan:
1. Reset, then stream 64 beats with load_data = (w*8+j) mod 128, load_valid held high -> load_ready high for exactly 64 cycles; table_full rises on the edge of beat 63; checksum = 2016.
2. Load with load_valid toggling every other cycle -> still exactly 64 accepts; table_full rises after the 64th accept only; checksum identical to scenario 1.
3. After load, sweep W,J over all 64 pairs, one per cycle -> each Cost equals the entry loaded at beat W*8+J, one cycle after the request; e.g. W=7, J=7 gives 63 the next cycle.
4. In SERVE, drive MatchCount=3, MinCost=10'd521, Valid=1 for one cycle -> res_match=3, res_cost=521, done=1 on the next edge. A later Valid with MatchCount=5 leaves res_match=3.
5. Assert Valid during LOAD at beat 20 -> done stays 0 and res_* stay 0; the load completes normally.
6. Pull RST low after 30 beats, release, reload 64 beats of value 127 -> checksum = 8128 and every Cost reads 127.
